// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv1d sequencing controller.
// State encodings are fixed so debug taps and traces stay comparable across builds.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_LEN   = 16;
  localparam int DEF_KERNEL_LEN = 3;

endpackage

// File: rtl/conv_idx_counter.sv
// Up-counter 0..MAX with clear priority, wrap at MAX; one-cycle update, no backpressure.
// Exposes the next value so the owner can register decoded outputs in step with it.
module conv_idx_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count_d,
  output logic         tc
);

  logic [W-1:0] count_q;

  assign tc = (count_q == W'(MAX));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = tc ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv1d_seq_controller.sv
// Sequences a shared MAC through valid-mode 1D convolution: KERNEL_LEN+2 cycles per result.
// EMIT holds out_valid/out_addr until out_ready; abort returns to IDLE from any state.
module conv1d_seq_controller
  import conv_pkg::*;
#(
  parameter int DATA_LEN   = DEF_DATA_LEN,
  parameter int KERNEL_LEN = DEF_KERNEL_LEN,
  parameter int ADDR_W     = $clog2(DATA_LEN),
  parameter int KADDR_W    = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  x_addr,
  output logic [KADDR_W-1:0] k_addr,
  output logic               mac_clr,
  output logic               mac_en,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               busy,
  output logic               done
);

  localparam int NUM_OUT = DATA_LEN - KERNEL_LEN + 1;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  out_idx_d;
  logic [KADDR_W-1:0] k_idx_d;
  logic               out_tc, k_tc;
  logic               out_clr, out_inc, k_clr, k_inc;

  logic [ADDR_W-1:0]  x_addr_q, x_addr_d;
  logic [KADDR_W-1:0] k_addr_q, k_addr_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic mac_clr_q, mac_clr_d, mac_en_q, mac_en_d;
  logic out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;

  // out_idx survives CLEAR/ACCUM/EMIT and is only zeroed between runs.
  assign out_clr = abort || (state_q == IDLE) || (state_q == DONE);
  assign out_inc = (state_q == EMIT) && out_ready && !out_tc;
  assign k_clr   = abort || (state_q != ACCUM);
  assign k_inc   = (state_q == ACCUM);

  conv_idx_counter #(.W(ADDR_W), .MAX(NUM_OUT - 1)) u_out_idx (
    .clk     (clk),
    .reset   (reset),
    .clr     (out_clr),
    .inc     (out_inc),
    .count_d (out_idx_d),
    .tc      (out_tc)
  );

  conv_idx_counter #(.W(KADDR_W), .MAX(KERNEL_LEN - 1)) u_k_idx (
    .clk     (clk),
    .reset   (reset),
    .clr     (k_clr),
    .inc     (k_inc),
    .count_d (k_idx_d),
    .tc      (k_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = ACCUM;
      ACCUM:   if (k_tc) state_d = EMIT;
      EMIT:    if (out_ready) state_d = out_tc ? DONE : CLEAR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Outputs are decoded from next state/counters so they are registered yet cycle-aligned.
  always_comb begin
    x_addr_d    = '0;
    k_addr_d    = '0;
    out_addr_d  = '0;
    mac_clr_d   = 1'b0;
    mac_en_d    = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    busy_d      = (state_d != IDLE);
    case (state_d)
      CLEAR: mac_clr_d = 1'b1;
      ACCUM: begin
        mac_en_d = 1'b1;
        x_addr_d = out_idx_d + ADDR_W'(k_idx_d);
        k_addr_d = k_idx_d;
      end
      EMIT: begin
        out_valid_d = 1'b1;
        out_addr_d  = out_idx_d;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_addr_q    <= '0;
      k_addr_q    <= '0;
      out_addr_q  <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_addr_q    <= x_addr_d;
      k_addr_q    <= k_addr_d;
      out_addr_q  <= out_addr_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign x_addr    = x_addr_q;
  assign k_addr    = k_addr_q;
  assign out_addr  = out_addr_q;
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv1d_seq_controller.sv
// Scoreboard bench: stimulus queues expected emits/done cycles, a negedge monitor checks them.
module tb_conv1d_seq_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic       abort = 1'b0;
  logic       out_ready = 1'b1;
  int         sel = 0;

  always #5 clk = ~clk;

  // Default instance (16 samples, 3 taps)
  logic [3:0] x0, oa0; logic [1:0] k0; logic clr0, en0, ov0, busy0, done0;
  // 4 samples, 1 tap
  logic [1:0] x1, oa1; logic [0:0] k1; logic clr1, en1, ov1, busy1, done1;
  // 4 samples, 4 taps
  logic [1:0] x2, oa2; logic [1:0] k2; logic clr2, en2, ov2, busy2, done2;

  conv1d_seq_controller u_def (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort), .out_ready(out_ready),
    .x_addr(x0), .k_addr(k0), .mac_clr(clr0), .mac_en(en0), .out_valid(ov0),
    .out_addr(oa0), .busy(busy0), .done(done0));

  conv1d_seq_controller #(.DATA_LEN(4), .KERNEL_LEN(1)) u_k1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort), .out_ready(out_ready),
    .x_addr(x1), .k_addr(k1), .mac_clr(clr1), .mac_en(en1), .out_valid(ov1),
    .out_addr(oa1), .busy(busy1), .done(done1));

  conv1d_seq_controller #(.DATA_LEN(4), .KERNEL_LEN(4)) u_kd (
    .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort), .out_ready(out_ready),
    .x_addr(x2), .k_addr(k2), .mac_clr(clr2), .mac_en(en2), .out_valid(ov2),
    .out_addr(oa2), .busy(busy2), .done(done2));

  logic [7:0] m_x, m_k, m_oa;
  logic       m_clr, m_en, m_ov, m_busy, m_done;

  always_comb begin
    m_x = '0; m_k = '0; m_oa = '0;
    m_clr = 1'b0; m_en = 1'b0; m_ov = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    case (sel)
      0: begin
        m_x = {4'd0, x0}; m_k = {6'd0, k0}; m_oa = {4'd0, oa0};
        m_clr = clr0; m_en = en0; m_ov = ov0; m_busy = busy0; m_done = done0;
      end
      1: begin
        m_x = {6'd0, x1}; m_k = {7'd0, k1}; m_oa = {6'd0, oa1};
        m_clr = clr1; m_en = en1; m_ov = ov1; m_busy = busy1; m_done = done1;
      end
      default: begin
        m_x = {6'd0, x2}; m_k = {6'd0, k2}; m_oa = {6'd0, oa2};
        m_clr = clr2; m_en = en2; m_ov = ov2; m_busy = busy2; m_done = done2;
      end
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         addr;
    int         nm;
    logic [31:0] xs;
    logic [31:0] ks;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  // Expected result i: taps j=0..K-1 read x[i+j], k[j], one byte per tap in order.
  function automatic exp_t mk(input int i, input int k);
    exp_t e;
    e.addr = i; e.nm = k; e.xs = '0; e.ks = '0;
    for (int j = 0; j < k; j++) begin
      e.xs = (e.xs << 8) | 32'(i + j);
      e.ks = (e.ks << 8) | 32'(j);
    end
    return e;
  endfunction

  task automatic push_run(input int n, input int k);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(i, k));
  endtask

  // Monitor
  logic [31:0] mon_xs = '0, mon_ks = '0;
  int          mon_nm = 0, mon_clrs = 0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (done_prev) begin
      check("busy_after_done", int'(m_busy), 0);
      done_prev = 1'b0;
    end
    if (!m_busy) begin
      mon_xs = '0; mon_ks = '0; mon_nm = 0; mon_clrs = 0;
    end else begin
      if (m_clr) begin
        mon_clrs++; mon_xs = '0; mon_ks = '0; mon_nm = 0;
      end
      if (m_en) begin
        mon_xs = {mon_xs[23:0], m_x};
        mon_ks = {mon_ks[23:0], m_k};
        mon_nm++;
      end
      if (m_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_emit", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_addr", int'(m_oa), e.addr);
          check("mac_en_count", mon_nm, e.nm);
          check("x_addr_seq", int'(mon_xs), int'(e.xs));
          check("k_addr_seq", int'(mon_ks), int'(e.ks));
          check("mac_clr_count", mon_clrs, 1);
          check("mac_en_in_emit", int'(m_en), 0);
        end
        mon_clrs = 0;
      end
      if (m_done) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", cyc - start_cyc + 1, done_q.pop_front());
        done_prev = 1'b1;
      end
    end
  end

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input int d);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (m_busy && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", int'(m_busy), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_emits_left"}, exp_q.size(), 0);
    check({tag, "_dones_left"}, done_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_def", int'({x0, k0, clr0, en0, ov0, oa0, busy0, done0}), 0);
    check("reset_outputs_k1", int'({x1, k1, clr1, en1, ov1, oa1, busy1, done1}), 0);
    check("reset_outputs_kd", int'({x2, k2, clr2, en2, ov2, oa2, busy2, done2}), 0);
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Nominal run with a stray start mid-run
    sel = 0;
    push_run(14, 3); done_q.push_back(71);
    do_start(0);
    s = start_cyc;
    step_to(s + 10);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_idle(200);
    check_drained("nominal");

    // Back-pressure at result 5
    push_run(14, 3); done_q.push_back(75);
    do_start(0);
    s = start_cyc;
    step_to(s + 28);
    out_ready = 1'b0;
    for (int c = 29; c <= 32; c++) begin
      step_to(s + c);
      check("bp_out_valid", int'(m_ov), 1);
      check("bp_out_addr", int'(m_oa), 5);
      check("bp_mac_en", int'(m_en), 0);
    end
    step_to(s + 33);
    out_ready = 1'b1;
    wait_idle(200);
    check_drained("backpressure");

    // Abort during ACCUM of result 7, then a fresh run
    push_run(7, 3);
    do_start(0);
    s = start_cyc;
    step_to(s + 36);
    check("abort_pre_mac_en", int'(m_en), 1);
    abort = 1'b1;
    step_to(s + 37);
    abort = 1'b0;
    check("abort_busy", int'(m_busy), 0);
    check("abort_out_valid", int'(m_ov), 0);
    repeat (5) begin @(posedge clk); #1; end
    check_drained("abort");
    push_run(14, 3); done_q.push_back(71);
    do_start(0);
    wait_idle(200);
    check_drained("after_abort");

    // Synchronous reset during EMIT of result 3, start held while in reset
    push_run(3, 3);
    do_start(0);
    s = start_cyc;
    step_to(s + 19);
    check("pre_reset_out_addr", int'(m_oa), 3);
    reset = 1'b0; out_ready = 1'b0; start_v[0] = 1'b1;
    step_to(s + 20);
    check("reset_run_outputs", int'({x0, k0, clr0, en0, ov0, oa0, busy0, done0}), 0);
    step_to(s + 21);
    check("reset_start_ignored", int'(busy0), 0);
    reset = 1'b1; start_v[0] = 1'b0; out_ready = 1'b1;
    step_to(s + 23);
    check("post_reset_busy", int'(busy0), 0);
    check_drained("reset");

    // start together with abort in IDLE
    start_v[0] = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0; abort = 1'b0;
    check("start_abort_busy", int'(busy0), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("start_abort_still_idle", int'(busy0), 0);

    // Single-tap kernel
    sel = 1;
    push_run(4, 1); done_q.push_back(13);
    do_start(1);
    wait_idle(100);
    check_drained("k1");

    // Kernel as long as the data
    sel = 2;
    push_run(1, 4); done_q.push_back(7);
    do_start(2);
    wait_idle(100);
    check_drained("kd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv1d_seq_controller.md
Name: conv1d_seq_controller

Overview:
- FSM controller that sequences a shared multiply-accumulate datapath through a valid-mode 1D convolution.
- Drives sample and kernel read addresses, MAC clear/enable strobes, and an output valid/ready handshake.
- Sits between the top-level start/done control and the MAC unit plus its sample/kernel memories.
- Produces DATA_LEN-KERNEL_LEN+1 results per run.

Parameters:
- DATA_LEN, 16, number of input samples in the sample memory.
- KERNEL_LEN, 3, number of kernel taps; constraint 1 <= KERNEL_LEN <= DATA_LEN.
- ADDR_W, $clog2(DATA_LEN), width of the sample and output addresses.
- KADDR_W, (KERNEL_LEN>1 ? $clog2(KERNEL_LEN) : 1), width of the kernel address.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; state cleared on rising clk when reset==0.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel the current run.
- out_ready  in  1  consumer accepts the current result.
- x_addr  out  ADDR_W  sample memory read address.
- k_addr  out  KADDR_W  kernel memory read address.
- mac_clr  out  1  clear the accumulator.
- mac_en  out  1  accumulate x[x_addr]*k[k_addr].
- out_valid  out  1  accumulator holds result out_addr.
- out_addr  out  ADDR_W  index of the current result.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at run completion.

Behaviour:
- Definitions: NUM_OUT = DATA_LEN-KERNEL_LEN+1. Registers are out_idx (ADDR_W bits) and k_idx (KADDR_W bits).
- Reset (reset==0 at an edge): state=IDLE, out_idx=0, k_idx=0. All outputs are 0, including addresses. Reset mid-run abandons the run with no done pulse.
- All outputs are Moore outputs decoded from state and registers.
- IDLE:
  - busy=0; outputs 0.
  - start==1 -> CLEAR, with out_idx=0 and k_idx=0.
- CLEAR:
  - mac_clr=1 for exactly one cycle.
  - k_idx=0 -> ACCUM.
- ACCUM:
  - mac_en=1, x_addr=out_idx+k_idx, k_addr=k_idx.
  - k_idx increments each cycle. When k_idx==KERNEL_LEN-1 -> EMIT, so there are exactly KERNEL_LEN ACCUM cycles.
  - The sum out_idx+k_idx never exceeds DATA_LEN-1, so there is no wrap.
- EMIT:
  - out_valid=1, out_addr=out_idx; mac_en=0.
  - Hold while out_ready==0, with out_valid, out_addr and the accumulator stable.
  - On out_valid&&out_ready: if out_idx==NUM_OUT-1 -> DONE; otherwise out_idx+1 -> CLEAR.
- DONE:
  - done=1 for one cycle -> IDLE; busy=1 in this cycle.
- Latency:
  - With out_ready held high, each result takes KERNEL_LEN+2 cycles.
  - done is high in cycle NUM_OUT*(KERNEL_LEN+2)+1 after the start edge.
- start while busy: ignored.
- start and abort together in IDLE: abort wins; stay IDLE.
- abort==1 in any non-IDLE state: next state IDLE, counters zeroed, no done pulse. This includes EMIT with out_ready==1; that result is discarded and the consumer must ignore it.
- Priority order: reset > abort > normal transitions.
- KERNEL_LEN==1: ACCUM lasts one cycle with k_addr=0.
- KERNEL_LEN==DATA_LEN: NUM_OUT=1.

Decomposition:
- Shared package conv_pkg:
  - state typedef with encodings IDLE=3'd0, CLEAR=3'd1, ACCUM=3'd2, EMIT=3'd3, DONE=3'd4.
  - Default DATA_LEN and KERNEL_LEN constants.
- Optional sub-module conv_idx_counter: a parameterised up-counter with clr, inc and terminal-count output. It is instantiated twice, for out_idx and k_idx.
- FSM next-state logic and output decode stay in the top module.

Test Plan:
- Nominal run: defaults, out_ready=1, start pulse -> 14 out_valid pulses.
  - out_addr sequence 0..13, each preceded by mac_clr and 3 mac_en cycles with k_addr 0,1,2.
  - x_addr=i,i+1,i+2 for result i.
  - done in cycle 71; busy deasserts on the next cycle.
- Back-pressure: out_ready=0 for 4 cycles at out_addr=5 -> out_valid holds, out_addr stays 5, mac_en=0 throughout. The run resumes on the handshake and done is delayed by exactly 4 cycles.
- Abort: abort=1 in ACCUM of result 7 -> IDLE next cycle, busy=0, no done. A following start produces out_addr from 0 again.
- Reset mid-run: reset=0 during EMIT of result 3 -> next cycle all outputs 0, state IDLE. start is ignored while reset==0.
- Boundary parameters: KERNEL_LEN=1, DATA_LEN=4 -> 4 results, each with mac_clr, 1 mac_en (k_addr=0), then emit; done in cycle 13.
- Boundary parameters: KERNEL_LEN=DATA_LEN=4 -> 1 result with x_addr 0..3; done in cycle 7.
- start during busy and start+abort in IDLE -> both have no effect on the sequence.
